// File: rtl/apb_bridge_fsm.sv
// APB2 transfer controller for the AHB-to-APB bridge: sequences SETUP/ACCESS
// from the decoder strobe and answers the AHB side with hreadyout/hrdata.
module apb_bridge_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 7
) (
    input  logic              pclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [NSLV-1:0]   psel_in,
    input  logic [DATA_W-1:0] prdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WWAIT  = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } state_t;

    state_t            state;
    logic [NSLV-1:0]   sel_hold;
    logic [DATA_W-1:0] hrdata_q;
    logic              accept;

    // A strobe with no slave selected is dropped as if it never came.
    assign accept = valid && hreadyout && (state == IDLE || state == ACCESS)
                    && (psel_in != '0);

    always_ff @(posedge pclk or posedge hreset) begin
        if (hreset) begin
            state     <= IDLE;
            sel_hold  <= '0;
            hrdata_q  <= '0;
            hreadyout <= 1'b1;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE, ACCESS: begin
                    penable <= 1'b0;
                    if (state == ACCESS && !pwrite)
                        hrdata_q <= prdata;
                    if (accept) begin
                        paddr     <= haddr;
                        sel_hold  <= psel_in;
                        pwrite    <= 1'b0;
                        hreadyout <= 1'b0;
                        // Writes wait one cycle for hwdata before SETUP.
                        if (hwrite) begin
                            psel  <= '0;
                            state <= WWAIT;
                        end else begin
                            psel  <= psel_in;
                            state <= SETUP;
                        end
                    end else begin
                        psel      <= '0;
                        pwrite    <= 1'b0;
                        hreadyout <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WWAIT: begin
                    pwdata <= hwdata;
                    psel   <= sel_hold;
                    pwrite <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                    state     <= ACCESS;
                end
                default: begin
                    psel      <= '0;
                    penable   <= 1'b0;
                    hreadyout <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign hrdata = (state == ACCESS && !pwrite) ? prdata : hrdata_q;

endmodule
